// File: rtl/cpu_types_pkg.sv
// Shared CPU types: instruction fields, ALU operations and the multicycle control enums.
package cpu_types_pkg;

  typedef enum logic [5:0] {
    OP_RTYPE = 6'h00, OP_J    = 6'h02, OP_JAL   = 6'h03, OP_BEQ  = 6'h04,
    OP_BNE   = 6'h05, OP_ADDI = 6'h08, OP_ADDIU = 6'h09, OP_SLTI = 6'h0a,
    OP_SLTIU = 6'h0b, OP_ANDI = 6'h0c, OP_ORI   = 6'h0d, OP_XORI = 6'h0e,
    OP_LUI   = 6'h0f, OP_LW   = 6'h23, OP_SW    = 6'h2b, OP_HALT = 6'h3f
  } opcode_t;

  typedef enum logic [5:0] {
    F_SLL = 6'h00, F_SRL = 6'h02, F_JR  = 6'h08, F_ADD = 6'h20, F_ADDU = 6'h21,
    F_SUB = 6'h22, F_SUBU = 6'h23, F_AND = 6'h24, F_OR = 6'h25, F_XOR = 6'h26,
    F_NOR = 6'h27, F_SLT = 6'h2a, F_SLTU = 6'h2b
  } funct_t;

  typedef enum logic [3:0] {
    ALU_SLL, ALU_SRL, ALU_ADD, ALU_SUB, ALU_AND,
    ALU_OR, ALU_XOR, ALU_NOR, ALU_SLT, ALU_SLTU
  } aluop_t;

  typedef enum logic [2:0] {
    S_FETCH = 3'd0, S_DECODE = 3'd1, S_EXEC = 3'd2, S_MEM = 3'd3,
    S_WB = 3'd4, S_HALTED = 3'd5, S_ERROR = 3'd6
  } mc_state_t;

  typedef enum logic [1:0] {PC_NEXT, PC_BRANCH, PC_JUMP, PC_RS} pcsrc_t;
  typedef enum logic [1:0] {B_RT, B_FOUR, B_IMM, B_IMM_SH2} alusrcb_t;
  typedef enum logic [1:0] {DST_RT, DST_RD, DST_RA} regdst_t;

  typedef enum logic [3:0] {
    CLS_RTYPE, CLS_ITYPE, CLS_LUI, CLS_LW, CLS_SW, CLS_BEQ, CLS_BNE,
    CLS_J, CLS_JAL, CLS_JR, CLS_HALT, CLS_ILLEGAL
  } instr_class_t;

  localparam logic [4:0] REG_RA = 5'd31;

endpackage

// File: rtl/multicycle_control_unit_if.sv
// Bundle of the control unit's connections, for integration and bench use.
interface multicycle_control_unit_if
  import cpu_types_pkg::*;
#(
  parameter int SHAM_W = 5
) (
  input logic CLK
);
  logic              nRST;
  opcode_t           opcode;
  funct_t            funct;
  logic [SHAM_W-1:0] shamt;
  logic              ihit, dhit, zero, overflow;
  logic              iREN, dREN, dWEN, IRWrite, PCWrite;
  logic [1:0]        PCSrc, ALUSrcB, RegDst;
  logic              ALUSrcA, ExtOp, RegWr, MemtoReg, LUI;
  aluop_t            ALUCtr;
  logic              halt, bus_err, illegal, ovf_trap;
  logic [2:0]        state_o;

  modport cu (
    input  CLK, nRST, opcode, funct, shamt, ihit, dhit, zero, overflow,
    output iREN, dREN, dWEN, IRWrite, PCWrite, PCSrc, ALUSrcA, ALUSrcB, ALUCtr,
           ExtOp, RegDst, RegWr, MemtoReg, LUI, halt, bus_err, illegal, ovf_trap, state_o
  );

  modport tb (
    input  CLK, iREN, dREN, dWEN, IRWrite, PCWrite, PCSrc, ALUSrcA, ALUSrcB, ALUCtr,
           ExtOp, RegDst, RegWr, MemtoReg, LUI, halt, bus_err, illegal, ovf_trap, state_o,
    output nRST, opcode, funct, shamt, ihit, dhit, zero, overflow
  );
endinterface

// File: rtl/mc_decode.sv
// Instruction decoder: classifies opcode/funct and picks the ALU operation and extension mode.
module mc_decode
  import cpu_types_pkg::*;
(
  input  opcode_t      opcode,
  input  funct_t       funct,
  output instr_class_t cls,
  output aluop_t       aluctr,
  output logic         extop,
  output logic         trap_op,
  output logic         illegal
);

  always_comb begin
    // NOTE: every output is given a default first so no path can infer a latch.
    cls     = CLS_ILLEGAL;
    aluctr  = ALU_ADD;
    extop   = 1'b0;
    trap_op = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        cls = CLS_RTYPE;
        case (funct)
          F_SLL:  aluctr = ALU_SLL;
          F_SRL:  aluctr = ALU_SRL;
          F_ADD:  begin aluctr = ALU_ADD; trap_op = 1'b1; end
          F_ADDU: aluctr = ALU_ADD;
          F_SUB:  begin aluctr = ALU_SUB; trap_op = 1'b1; end
          F_SUBU: aluctr = ALU_SUB;
          F_AND:  aluctr = ALU_AND;
          F_OR:   aluctr = ALU_OR;
          F_XOR:  aluctr = ALU_XOR;
          F_NOR:  aluctr = ALU_NOR;
          F_SLT:  aluctr = ALU_SLT;
          F_SLTU: aluctr = ALU_SLTU;
          F_JR:   cls = CLS_JR;
          default: cls = CLS_ILLEGAL;
        endcase
      end
      OP_ADDI:  begin cls = CLS_ITYPE; extop = 1'b1; trap_op = 1'b1; end
      OP_ADDIU: begin cls = CLS_ITYPE; extop = 1'b1; end
      OP_SLTI:  begin cls = CLS_ITYPE; extop = 1'b1; aluctr = ALU_SLT;  end
      OP_SLTIU: begin cls = CLS_ITYPE; extop = 1'b1; aluctr = ALU_SLTU; end
      OP_ANDI:  begin cls = CLS_ITYPE; aluctr = ALU_AND; end
      OP_ORI:   begin cls = CLS_ITYPE; aluctr = ALU_OR;  end
      OP_XORI:  begin cls = CLS_ITYPE; aluctr = ALU_XOR; end
      OP_LUI:   cls = CLS_LUI;
      OP_LW:    begin cls = CLS_LW;  extop = 1'b1; end
      OP_SW:    begin cls = CLS_SW;  extop = 1'b1; end
      OP_BEQ:   begin cls = CLS_BEQ; extop = 1'b1; aluctr = ALU_SUB; end
      OP_BNE:   begin cls = CLS_BNE; extop = 1'b1; aluctr = ALU_SUB; end
      OP_J:     cls = CLS_J;
      OP_JAL:   cls = CLS_JAL;
      OP_HALT:  cls = CLS_HALT;
      default:  cls = CLS_ILLEGAL;
    endcase
  end

  assign illegal = (cls == CLS_ILLEGAL);

endmodule

// File: rtl/multicycle_control_unit.sv
// Multicycle control FSM: sequences FETCH/DECODE/EXEC/MEM/WB, waits on memory hits with a timeout.
module multicycle_control_unit
  import cpu_types_pkg::*;
#(
  parameter int SHAM_W      = 5,
  parameter int MEM_TIMEOUT = 255,
  parameter bit TRAP_OVF    = 1'b1
) (
  input  logic              CLK,
  input  logic              nRST,
  input  opcode_t           opcode,
  input  funct_t            funct,
  input  logic [SHAM_W-1:0] shamt,
  input  logic              ihit,
  input  logic              dhit,
  input  logic              zero,
  input  logic              overflow,
  output logic              iREN,
  output logic              dREN,
  output logic              dWEN,
  output logic              IRWrite,
  output logic              PCWrite,
  output logic [1:0]        PCSrc,
  output logic              ALUSrcA,
  output logic [1:0]        ALUSrcB,
  output aluop_t            ALUCtr,
  output logic              ExtOp,
  output logic [1:0]        RegDst,
  output logic              RegWr,
  output logic              MemtoReg,
  output logic              LUI,
  output logic              halt,
  output logic              bus_err,
  output logic              illegal,
  output logic              ovf_trap,
  output logic [2:0]        state_o
);

  localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);

  mc_state_t        state, state_next;
  logic [CNT_W-1:0] wait_cnt;
  instr_class_t     cls;
  aluop_t           dec_aluctr;
  logic             dec_extop, dec_trap, dec_illegal;
  logic             pending, mem_hit, timed_out;

  // The ALU takes shamt straight from the IR; sequencing never needs it.
  logic shamt_unused;
  assign shamt_unused = ^shamt;

  mc_decode u_decode (
    .opcode  (opcode),
    .funct   (funct),
    .cls     (cls),
    .aluctr  (dec_aluctr),
    .extop   (dec_extop),
    .trap_op (dec_trap),
    .illegal (dec_illegal)
  );

  assign pending   = (state == S_FETCH) || (state == S_MEM);
  assign mem_hit   = (state == S_FETCH) ? ihit : dhit;
  assign timed_out = (wait_cnt == CNT_W'(MEM_TIMEOUT));

  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (!nRST) begin
      state    <= S_FETCH;
      wait_cnt <= '0;
    end else begin
      state <= state_next;
      if (!pending || state_next != state || mem_hit) wait_cnt <= '0;
      else                                            wait_cnt <= wait_cnt + 1'b1;
    end
  end

  always_comb begin
    state_next = state;
    iREN = 1'b0;  dREN = 1'b0;  dWEN = 1'b0;  IRWrite = 1'b0;  PCWrite = 1'b0;
    PCSrc = PC_NEXT;  ALUSrcA = 1'b0;  ALUSrcB = B_RT;  ALUCtr = ALU_ADD;
    ExtOp = 1'b0;  RegDst = DST_RT;  RegWr = 1'b0;  MemtoReg = 1'b0;  LUI = 1'b0;
    illegal = 1'b0;  ovf_trap = 1'b0;
    case (state)
      S_FETCH: begin
        iREN    = 1'b1;
        ALUSrcB = B_FOUR;
        if (ihit) begin
          IRWrite    = 1'b1;
          PCWrite    = 1'b1;
          state_next = S_DECODE;
        end else if (timed_out) begin
          state_next = S_ERROR;
        end
      end
      S_DECODE: begin
        // Branch target is precomputed into ALUOut while the opcode is examined.
        ALUSrcB = B_IMM_SH2;
        ExtOp   = 1'b1;
        if (cls == CLS_HALT)   state_next = S_HALTED;
        else if (dec_illegal) begin
          illegal    = 1'b1;
          state_next = S_FETCH;
        end else               state_next = S_EXEC;
      end
      S_EXEC: begin
        state_next = S_FETCH;
        case (cls)
          CLS_RTYPE: begin
            ALUSrcA = 1'b1;  ALUSrcB = B_RT;  ALUCtr = dec_aluctr;  state_next = S_WB;
          end
          CLS_ITYPE: begin
            ALUSrcA = 1'b1;  ALUSrcB = B_IMM;  ExtOp = dec_extop;  ALUCtr = dec_aluctr;
            state_next = S_WB;
          end
          CLS_LUI: state_next = S_WB;
          CLS_LW, CLS_SW: begin
            ALUSrcA = 1'b1;  ALUSrcB = B_IMM;  ExtOp = 1'b1;  state_next = S_MEM;
          end
          CLS_BEQ, CLS_BNE: begin
            ALUSrcA = 1'b1;  ALUSrcB = B_RT;  ALUCtr = ALU_SUB;  PCSrc = PC_BRANCH;
            PCWrite = (cls == CLS_BEQ) ? zero : ~zero;
          end
          CLS_J:   begin PCSrc = PC_JUMP;  PCWrite = 1'b1; end
          CLS_JAL: begin
            // The link value is the PC already advanced during FETCH.
            PCSrc = PC_JUMP;  PCWrite = 1'b1;  RegWr = 1'b1;  RegDst = DST_RA;
          end
          CLS_JR:  begin PCSrc = PC_RS;  PCWrite = 1'b1; end
          default: ;
        endcase
      end
      S_MEM: begin
        if (cls == CLS_LW) dREN = 1'b1;
        else               dWEN = 1'b1;
        if (dhit)           state_next = (cls == CLS_LW) ? S_WB : S_FETCH;
        else if (timed_out) state_next = S_ERROR;
      end
      S_WB: begin
        RegDst     = (cls == CLS_RTYPE) ? DST_RD : DST_RT;
        MemtoReg   = (cls == CLS_LW);
        LUI        = (cls == CLS_LUI);
        state_next = S_FETCH;
        // overflow here is the ALU flag registered at the end of EXEC.
        if (TRAP_OVF && dec_trap && overflow) ovf_trap = 1'b1;
        else                                  RegWr    = 1'b1;
      end
      S_HALTED, S_ERROR: ;
      default: state_next = S_FETCH;
    endcase
    // Strobes stay quiet for the whole reset assertion, not just after the edge.
    if (!nRST) begin
      iREN = 1'b0;  dREN = 1'b0;  dWEN = 1'b0;  IRWrite = 1'b0;  PCWrite = 1'b0;
      RegWr = 1'b0;  illegal = 1'b0;  ovf_trap = 1'b0;
    end
  end

  assign halt    = (state == S_HALTED) || (state == S_ERROR);
  assign bus_err = (state == S_ERROR);
  assign state_o = state;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Scenario bench for multicycle_control_unit: per-cycle expectations queued, then compared at negedge.
module tb_multicycle_control_unit;
  import cpu_types_pkg::*;

  localparam int TO = 4;

  logic       CLK, nRST;
  opcode_t    opcode;
  funct_t     funct;
  logic [4:0] shamt;
  logic       ihit, dhit, zero, overflow;
  logic       iREN, dREN, dWEN, IRWrite, PCWrite, ALUSrcA, ExtOp, RegWr, MemtoReg, LUI;
  logic [1:0] PCSrc, ALUSrcB, RegDst;
  aluop_t     ALUCtr;
  logic       halt, bus_err, illegal, ovf_trap;
  logic [2:0] state_o;

  multicycle_control_unit #(.SHAM_W(5), .MEM_TIMEOUT(TO), .TRAP_OVF(1'b1)) dut (
    .CLK(CLK), .nRST(nRST), .opcode(opcode), .funct(funct), .shamt(shamt),
    .ihit(ihit), .dhit(dhit), .zero(zero), .overflow(overflow),
    .iREN(iREN), .dREN(dREN), .dWEN(dWEN), .IRWrite(IRWrite), .PCWrite(PCWrite),
    .PCSrc(PCSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUCtr(ALUCtr), .ExtOp(ExtOp),
    .RegDst(RegDst), .RegWr(RegWr), .MemtoReg(MemtoReg), .LUI(LUI), .halt(halt),
    .bus_err(bus_err), .illegal(illegal), .ovf_trap(ovf_trap), .state_o(state_o)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef enum {
    G_IREN, G_DREN, G_DWEN, G_IRWRITE, G_PCWRITE, G_PCSRC, G_ALUSRCA, G_ALUSRCB,
    G_ALUCTR, G_REGDST, G_REGWR, G_MEMTOREG, G_HALT, G_BUSERR, G_ILLEGAL, G_OVF, G_STATE
  } sig_e;

  typedef struct {
    int         cyc;
    sig_e       sig;
    logic [3:0] exp;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  function automatic logic [3:0] sample(sig_e s);
    case (s)
      G_IREN:     return {3'b0, iREN};
      G_DREN:     return {3'b0, dREN};
      G_DWEN:     return {3'b0, dWEN};
      G_IRWRITE:  return {3'b0, IRWrite};
      G_PCWRITE:  return {3'b0, PCWrite};
      G_PCSRC:    return {2'b0, PCSrc};
      G_ALUSRCA:  return {3'b0, ALUSrcA};
      G_ALUSRCB:  return {2'b0, ALUSrcB};
      G_ALUCTR:   return ALUCtr;
      G_REGDST:   return {2'b0, RegDst};
      G_REGWR:    return {3'b0, RegWr};
      G_MEMTOREG: return {3'b0, MemtoReg};
      G_HALT:     return {3'b0, halt};
      G_BUSERR:   return {3'b0, bus_err};
      G_ILLEGAL:  return {3'b0, illegal};
      G_OVF:      return {3'b0, ovf_trap};
      default:    return {1'b0, state_o};
    endcase
  endfunction

  task automatic expect_at(input int c, input sig_e s, input logic [3:0] v);
    sb.push_back('{cyc: c, sig: s, exp: v});
  endtask

  task automatic test_reset();
    exp_t e;
    expect_at(0, G_IREN, 0);  expect_at(0, G_IRWRITE, 0);  expect_at(0, G_PCWRITE, 0);
    expect_at(0, G_STATE, 0); expect_at(0, G_HALT, 0);     expect_at(0, G_BUSERR, 0);
    expect_at(1, G_IREN, 1);  expect_at(1, G_STATE, 0);
    expect_at(2, G_IREN, 0);  expect_at(2, G_IRWRITE, 0);
    for (int c = 0; c < 3; c++) begin
      nRST = (c == 1);
      ihit = (c != 1);
      @(negedge CLK);
      while (sb.size() > 0 && sb[0].cyc == c) begin
        e = sb.pop_front();
        checks++;
        if (sample(e.sig) !== e.exp) begin
          failures++;
          $display("FAIL reset.%s cyc=%0d got=%0h exp=%0h", e.sig.name(), c, sample(e.sig), e.exp);
        end
      end
      @(posedge CLK); #1;
    end
    nRST = 1'b1;
    ihit = 1'b0;
  endtask

  task automatic test_add();
    exp_t e;
    opcode = OP_RTYPE;  funct = F_ADD;  overflow = 1'b0;
    expect_at(0, G_STATE, 0);  expect_at(0, G_IREN, 1);  expect_at(0, G_IRWRITE, 0);
    expect_at(1, G_IREN, 1);
    expect_at(2, G_IREN, 1);   expect_at(2, G_IRWRITE, 1);  expect_at(2, G_PCWRITE, 1);
    expect_at(2, G_PCSRC, 0);  expect_at(2, G_ALUSRCB, 1);
    expect_at(3, G_STATE, 1);  expect_at(3, G_IREN, 0);  expect_at(3, G_ALUSRCB, 3);
    expect_at(4, G_STATE, 2);  expect_at(4, G_ALUSRCA, 1);  expect_at(4, G_ALUSRCB, 0);
    expect_at(4, G_ALUCTR, ALU_ADD);
    expect_at(5, G_STATE, 4);  expect_at(5, G_REGWR, 1);  expect_at(5, G_REGDST, 1);
    expect_at(5, G_MEMTOREG, 0);  expect_at(5, G_OVF, 0);
    for (int c = 0; c < 6; c++) begin
      ihit = (c == 2);
      @(negedge CLK);
      while (sb.size() > 0 && sb[0].cyc == c) begin
        e = sb.pop_front();
        checks++;
        if (sample(e.sig) !== e.exp) begin
          failures++;
          $display("FAIL add.%s cyc=%0d got=%0h exp=%0h", e.sig.name(), c, sample(e.sig), e.exp);
        end
      end
      @(posedge CLK); #1;
    end
  endtask

  task automatic test_lw_sw();
    exp_t e;
    expect_at(0, G_STATE, 0);  expect_at(0, G_IRWRITE, 1);
    expect_at(1, G_STATE, 1);
    expect_at(2, G_STATE, 2);  expect_at(2, G_ALUSRCA, 1);  expect_at(2, G_ALUSRCB, 2);
    expect_at(3, G_STATE, 3);  expect_at(3, G_DREN, 1);  expect_at(3, G_DWEN, 0);
    expect_at(4, G_DREN, 1);
    expect_at(5, G_DREN, 1);   expect_at(5, G_STATE, 3);
    expect_at(6, G_STATE, 4);  expect_at(6, G_DREN, 0);  expect_at(6, G_MEMTOREG, 1);
    expect_at(6, G_REGWR, 1);  expect_at(6, G_REGDST, 0);
    expect_at(7, G_STATE, 0);  expect_at(7, G_IRWRITE, 1);
    expect_at(8, G_STATE, 1);
    expect_at(9, G_STATE, 2);
    expect_at(10, G_STATE, 3); expect_at(10, G_DWEN, 1);  expect_at(10, G_DREN, 0);
    for (int c = 0; c < 11; c++) begin
      opcode = (c < 7) ? OP_LW : OP_SW;
      ihit   = (c == 0) || (c == 7);
      dhit   = (c == 5) || (c == 10);
      @(negedge CLK);
      while (sb.size() > 0 && sb[0].cyc == c) begin
        e = sb.pop_front();
        checks++;
        if (sample(e.sig) !== e.exp) begin
          failures++;
          $display("FAIL lw_sw.%s cyc=%0d got=%0h exp=%0h", e.sig.name(), c, sample(e.sig), e.exp);
        end
      end
      @(posedge CLK); #1;
    end
    dhit = 1'b0;
  endtask

  task automatic test_branch();
    exp_t e;
    zero = 1'b1;
    expect_at(0, G_STATE, 0);
    expect_at(2, G_STATE, 2);  expect_at(2, G_PCWRITE, 1);  expect_at(2, G_PCSRC, 1);
    expect_at(2, G_ALUCTR, ALU_SUB);
    expect_at(3, G_STATE, 0);
    expect_at(5, G_STATE, 2);  expect_at(5, G_PCWRITE, 0);  expect_at(5, G_PCSRC, 1);
    expect_at(6, G_STATE, 0);
    expect_at(8, G_STATE, 2);  expect_at(8, G_PCWRITE, 1);  expect_at(8, G_PCSRC, 2);
    expect_at(8, G_REGWR, 1);  expect_at(8, G_REGDST, 2);
    for (int c = 0; c < 9; c++) begin
      opcode = (c < 3) ? OP_BEQ : (c < 6) ? OP_BNE : OP_JAL;
      ihit   = (c % 3 == 0);
      @(negedge CLK);
      while (sb.size() > 0 && sb[0].cyc == c) begin
        e = sb.pop_front();
        checks++;
        if (sample(e.sig) !== e.exp) begin
          failures++;
          $display("FAIL branch.%s cyc=%0d got=%0h exp=%0h", e.sig.name(), c, sample(e.sig), e.exp);
        end
      end
      @(posedge CLK); #1;
    end
    zero = 1'b0;
  endtask

  task automatic test_timeout();
    exp_t e;
    opcode = OP_J;
    expect_at(0, G_STATE, 0);   expect_at(0, G_IREN, 1);
    expect_at(3, G_STATE, 0);
    expect_at(4, G_STATE, 0);   expect_at(4, G_IREN, 1);  expect_at(4, G_IRWRITE, 1);
    expect_at(5, G_STATE, 1);
    expect_at(6, G_STATE, 2);   expect_at(6, G_PCWRITE, 1);  expect_at(6, G_PCSRC, 2);
    expect_at(7, G_STATE, 0);
    expect_at(11, G_STATE, 0);  expect_at(11, G_IREN, 1);
    expect_at(12, G_STATE, 6);  expect_at(12, G_BUSERR, 1);  expect_at(12, G_HALT, 1);
    expect_at(12, G_IREN, 0);
    expect_at(13, G_STATE, 6);  expect_at(13, G_IREN, 0);  expect_at(13, G_IRWRITE, 0);
    expect_at(14, G_IREN, 0);
    expect_at(15, G_STATE, 0);  expect_at(15, G_HALT, 0);  expect_at(15, G_BUSERR, 0);
    expect_at(15, G_IREN, 1);
    expect_at(16, G_STATE, 1);
    expect_at(17, G_STATE, 2);
    for (int c = 0; c < 18; c++) begin
      ihit = (c == 4) || (c == 13) || (c == 15);
      nRST = (c != 14);
      @(negedge CLK);
      while (sb.size() > 0 && sb[0].cyc == c) begin
        e = sb.pop_front();
        checks++;
        if (sample(e.sig) !== e.exp) begin
          failures++;
          $display("FAIL timeout.%s cyc=%0d got=%0h exp=%0h", e.sig.name(), c, sample(e.sig), e.exp);
        end
      end
      @(posedge CLK); #1;
    end
    nRST = 1'b1;
  endtask

  task automatic test_ovf_illegal_halt();
    exp_t    e;
    opcode_t op_bad;
    op_bad = opcode_t'(6'b111110);
    funct  = F_ADD;
    overflow = 1'b1;
    expect_at(2, G_STATE, 2);
    expect_at(3, G_STATE, 4);  expect_at(3, G_REGWR, 0);  expect_at(3, G_OVF, 1);
    expect_at(4, G_STATE, 0);  expect_at(4, G_OVF, 0);
    expect_at(5, G_STATE, 1);  expect_at(5, G_ILLEGAL, 1);
    expect_at(6, G_STATE, 0);  expect_at(6, G_ILLEGAL, 0);
    expect_at(8, G_STATE, 5);  expect_at(8, G_HALT, 1);  expect_at(8, G_IREN, 0);
    expect_at(9, G_STATE, 5);  expect_at(9, G_HALT, 1);  expect_at(9, G_IRWRITE, 0);
    expect_at(9, G_BUSERR, 0);
    expect_at(10, G_HALT, 1);
    expect_at(11, G_STATE, 0); expect_at(11, G_HALT, 0);  expect_at(11, G_IREN, 1);
    expect_at(13, G_STATE, 2);
    for (int c = 0; c < 14; c++) begin
      opcode = (c < 4) ? OP_RTYPE : (c < 6) ? op_bad : (c < 11) ? OP_HALT : OP_J;
      ihit   = (c == 0) || (c == 4) || (c == 6) || (c == 9) || (c == 11);
      nRST   = (c != 10);
      @(negedge CLK);
      while (sb.size() > 0 && sb[0].cyc == c) begin
        e = sb.pop_front();
        checks++;
        if (sample(e.sig) !== e.exp) begin
          failures++;
          $display("FAIL ovf_ill_halt.%s cyc=%0d got=%0h exp=%0h", e.sig.name(), c, sample(e.sig), e.exp);
        end
      end
      @(posedge CLK); #1;
    end
    nRST = 1'b1;
    overflow = 1'b0;
  endtask

  task automatic test_reset_in_mem();
    exp_t e;
    opcode = OP_SW;
    expect_at(3, G_STATE, 3);  expect_at(3, G_DWEN, 1);
    expect_at(4, G_STATE, 3);  expect_at(4, G_DWEN, 0);  expect_at(4, G_DREN, 0);
    expect_at(5, G_STATE, 0);  expect_at(5, G_IREN, 1);  expect_at(5, G_DWEN, 0);
    for (int c = 0; c < 6; c++) begin
      ihit = (c == 0);
      dhit = (c == 4);
      nRST = (c != 4);
      @(negedge CLK);
      while (sb.size() > 0 && sb[0].cyc == c) begin
        e = sb.pop_front();
        checks++;
        if (sample(e.sig) !== e.exp) begin
          failures++;
          $display("FAIL reset_mem.%s cyc=%0d got=%0h exp=%0h", e.sig.name(), c, sample(e.sig), e.exp);
        end
      end
      @(posedge CLK); #1;
    end
    nRST = 1'b1;
    dhit = 1'b0;
  endtask

  initial begin
    nRST = 1'b0;  opcode = OP_RTYPE;  funct = F_ADD;  shamt = 5'd0;
    ihit = 1'b0;  dhit = 1'b0;  zero = 1'b0;  overflow = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    test_reset();
    test_add();
    test_lw_sw();
    test_branch();
    test_timeout();
    test_ovf_illegal_halt();
    test_reset_in_mem();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
